hex_pager: RTL

- Sits directly upstream of the 4-digit seven-segment scanner and drives its hex/error/error_code inputs.
- Accepts 32-bit result words from the machine core over a valid/ready handshake.
- Pages the word across the 4-digit display as low and high halves, selected by auto-alternation or a debounced push button.
- Latches a sticky error code until the operator clears it.

---
 rtl/display_pkg.sv | 19 +
 rtl/debounce.sv | 33 +++
 rtl/hex_pager.sv | 130 +++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared display types: the pager FSM state and the error codes that the core,
// the pager and the seven-segment scanner all agree on.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW_LO,
    SHOW_HI,
    ERROR
  } pager_state_t;

  localparam logic [3:0] ERR_NONE       = 4'h0;
  localparam logic [3:0] ERR_OVERFLOW   = 4'h1;
  localparam logic [3:0] ERR_DIV_ZERO   = 4'h2;
  localparam logic [3:0] ERR_BAD_OPCODE = 4'h3;
  localparam logic [3:0] ERR_BUS        = 4'h4;
  localparam logic [3:0] ERR_WATCHDOG   = 4'h5;

endpackage

// File: rtl/debounce.sv
// Level debouncer: dout follows din only after din has differed from dout for
// CYCLES consecutive clocks. Any return to the current level restarts the count.
module debounce #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= 1'b0;
      cnt  <= '0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hex_pager.sv
// Pages a 32-bit result word across a 4-digit display (low/high half by timer
// or debounced button) and latches a sticky error code until cleared.
module hex_pager
  import display_pkg::*;
#(
  parameter int AUTO_PAGE_CYCLES = 200_000_000,
  parameter int DEBOUNCE_CYCLES  = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        err_valid,
  input  logic [3:0]  err_code,
  input  logic        err_clear,
  input  logic        page_btn,
  output logic [15:0] hex,
  output logic        error,
  output logic [3:0]  error_code,
  output logic        page
);

  localparam int TW = (AUTO_PAGE_CYCLES > 1) ? $clog2(AUTO_PAGE_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(AUTO_PAGE_CYCLES - 1);

  pager_state_t  state_q, state_d;
  logic [31:0]   word_q, word_d;
  logic          have_word_q, have_word_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   hex_d;
  logic          error_d;
  logic [3:0]    error_code_d;
  logic          btn_db, btn_q, btn_rise;
  logic          accept, showing;

  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (page_btn),
    .dout (btn_db)
  );

  assign in_ready = (state_q != ERROR);
  assign accept   = in_valid && in_ready;
  assign btn_rise = btn_db && !btn_q;
  assign showing  = (state_q == SHOW_LO) || (state_q == SHOW_HI);

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    have_word_d  = have_word_q;
    timer_d      = timer_q;
    error_d      = error;
    error_code_d = error_code;

    // The handshake completes whenever ready is high, even if an error arrives.
    if (accept) begin
      word_d      = in_data;
      have_word_d = 1'b1;
    end

    if (state_q == ERROR) begin
      if (err_clear) begin
        error_d = 1'b0;
        state_d = have_word_q ? SHOW_LO : IDLE;
        timer_d = '0;
      end
    end else if (err_valid) begin
      error_code_d = err_code;
      error_d      = 1'b1;
      state_d      = ERROR;
    end else if (accept) begin
      state_d = SHOW_LO;
      timer_d = '0;
    end else if (showing) begin
      // Button has priority so a coincident auto wrap yields a single toggle.
      if (btn_rise) begin
        state_d = (state_q == SHOW_LO) ? SHOW_HI : SHOW_LO;
        timer_d = '0;
      end else if (word_q[31:16] != 16'h0000) begin
        if (timer_q == TIMER_MAX) begin
          state_d = (state_q == SHOW_LO) ? SHOW_HI : SHOW_LO;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end else begin
        timer_d = '0;
      end
    end
  end

  always_comb begin
    hex_d = hex;
    case (state_d)
      SHOW_LO: hex_d = word_d[15:0];
      SHOW_HI: hex_d = word_d[31:16];
      IDLE:    hex_d = 16'h0000;
      default: hex_d = hex;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      have_word_q <= 1'b0;
      timer_q     <= '0;
      btn_q       <= 1'b0;
      hex         <= '0;
      error       <= 1'b0;
      error_code  <= '0;
      page        <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      have_word_q <= have_word_d;
      timer_q     <= timer_d;
      btn_q       <= btn_db;
      hex         <= hex_d;
      error       <= error_d;
      error_code  <= error_code_d;
      page        <= (state_d == SHOW_HI);
    end
  end

endmodule
